// File: rtl/bus_write_logger.sv
// Passive bus write logger: filters snooped writes through N_CH address windows
// and records them in a circular buffer that the host drains through a register port.
module bus_write_logger #(
  parameter int          DEPTH     = 16,
  parameter int          N_CH      = 2,
  parameter int          TS_W      = 16,
  parameter logic [31:0] SELF_BASE = 32'h0010_0000,
  parameter logic [31:0] SELF_MASK = 32'hFFFF_FF00
) (
  input  logic        clk_i,
  input  logic        arst_n_i,
  input  logic        snoop_req_i,
  input  logic        snoop_ack_i,
  input  logic        snoop_we_i,
  input  logic [31:0] snoop_addr_i,
  input  logic [3:0]  snoop_be_i,
  input  logic [31:0] snoop_wdata_i,
  input  logic        host_req_i,
  input  logic        host_we_i,
  input  logic [7:0]  host_addr_i,
  input  logic [31:0] host_wdata_i,
  output logic        host_ack_o,
  output logic        host_resp_o,
  output logic [31:0] host_rdata_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [5:0] A_CTRL      = 6'h00;
  localparam logic [5:0] A_STATUS    = 6'h01;
  localparam logic [5:0] A_DROPPED   = 6'h02;
  localparam int         A_BASE0     = 4;
  localparam logic [5:0] A_HEAD_TS   = 6'h10;
  localparam logic [5:0] A_HEAD_ADDR = 6'h11;
  localparam logic [5:0] A_HEAD_DATA = 6'h12;
  localparam logic [5:0] A_POP       = 6'h13;
  localparam logic [5:0] A_HEAD_INFO = 6'h14;

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [1:0]      ch;
    logic [3:0]      be;
    logic [31:0]     addr;
    logic [31:0]     data;
  } entry_t;

  logic              en_q, wrap_q;
  logic [N_CH-1:0]   ch_en_q;
  logic [31:0]       base_q [N_CH];
  logic [31:0]       mask_q [N_CH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  logic [31:0]       dropped_q;
  logic              ovf_q;
  logic [TS_W-1:0]   ts_q;
  entry_t            mem_q [DEPTH];
  logic              resp_q;
  logic [31:0]       rdata_q;

  logic [5:0]  word;
  logic        host_wr, host_rd;
  logic        clr, pop, full, empty;
  logic        hit, self_hit, cap;
  logic [1:0]  hit_ch;
  logic        mem_we;
  entry_t      cap_entry, head_e;
  logic [31:0] rd_mux;
  logic        unused_addr_lsb;

  assign word            = host_addr_i[7:2];
  assign unused_addr_lsb = ^host_addr_i[1:0];
  assign host_wr         = host_req_i & host_we_i;
  assign host_rd         = host_req_i & ~host_we_i;
  assign host_ack_o      = host_req_i;
  assign host_resp_o     = resp_q;
  assign host_rdata_o    = rdata_q;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign clr   = host_wr && (word == A_CTRL) && host_wdata_i[2];
  assign pop   = host_wr && (word == A_POP) && !empty;

  // Scan from the top so the lowest matching channel wins.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    hit    = 1'b0;
    hit_ch = 2'd0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (ch_en_q[k] && ((snoop_addr_i & mask_q[k]) == (base_q[k] & mask_q[k]))) begin
        hit    = 1'b1;
        hit_ch = 2'(k);
      end
    end
  end

  assign self_hit = ((snoop_addr_i & SELF_MASK) == (SELF_BASE & SELF_MASK));
  assign cap      = snoop_req_i & snoop_ack_i & snoop_we_i & en_q & hit & ~self_hit;
  // A full buffer still accepts the write if a pop frees the slot or wrap mode overwrites.
  assign mem_we   = cap & ~clr & (~full | pop | wrap_q);

  always_comb begin
    cap_entry      = '0;
    cap_entry.ts   = ts_q;
    cap_entry.ch   = hit_ch;
    cap_entry.be   = snoop_be_i;
    cap_entry.addr = snoop_addr_i;
    cap_entry.data = snoop_wdata_i;
  end

  assign head_e = mem_q[head_q];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      en_q    <= 1'b0;
      wrap_q  <= 1'b0;
      ch_en_q <= '0;
      for (int k = 0; k < N_CH; k++) begin
        base_q[k] <= '0;
        mask_q[k] <= '0;
      end
    end else if (host_wr) begin
      if (word == A_CTRL) begin
        en_q    <= host_wdata_i[0];
        wrap_q  <= host_wdata_i[1];
        ch_en_q <= host_wdata_i[8 +: N_CH];
      end
      for (int k = 0; k < N_CH; k++) begin
        if (word == 6'(A_BASE0 + 2 * k))     base_q[k] <= host_wdata_i;
        if (word == 6'(A_BASE0 + 2 * k + 1)) mask_q[k] <= host_wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      dropped_q <= '0;
      ovf_q     <= 1'b0;
      ts_q      <= '0;
    end else if (clr) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      dropped_q <= '0;
      ovf_q     <= 1'b0;
      ts_q      <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (cap) begin
        if (!full || pop) begin
          tail_q <= tail_q + 1'b1;
          if (!pop) count_q <= count_q + 1'b1;
        end else begin
          ovf_q <= 1'b1;
          if (dropped_q != 32'hFFFF_FFFF) dropped_q <= dropped_q + 1;
          if (wrap_q) begin
            tail_q <= tail_q + 1'b1;
            head_q <= head_q + 1'b1;
          end
        end
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
        if (!cap) count_q <= count_q - 1'b1;
      end
    end
  end

  // NOTE: buffer storage has no reset; EMPTY gates every head read, so stale contents never leak.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[tail_q] <= cap_entry;
  end

  always_comb begin
    rd_mux = '0;
    case (word)
      A_CTRL:      rd_mux = (32'(ch_en_q) << 8) | {30'b0, wrap_q, en_q};
      A_STATUS:    rd_mux = {13'b0, ovf_q, empty, full, 16'(count_q)};
      A_DROPPED:   rd_mux = dropped_q;
      A_HEAD_TS:   rd_mux = empty ? '0 : 32'(head_e.ts);
      A_HEAD_ADDR: rd_mux = empty ? '0 : head_e.addr;
      A_HEAD_DATA: rd_mux = empty ? '0 : head_e.data;
      A_HEAD_INFO: rd_mux = empty ? '0 : {26'b0, head_e.ch, head_e.be};
      default:     rd_mux = '0;
    endcase
    for (int k = 0; k < N_CH; k++) begin
      if (word == 6'(A_BASE0 + 2 * k))     rd_mux = base_q[k];
      if (word == 6'(A_BASE0 + 2 * k + 1)) rd_mux = mask_q[k];
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      resp_q <= host_rd;
      if (host_rd) rdata_q <= rd_mux;
    end
  end

endmodule

// File: tb/tb_bus_write_logger.sv
// Self-checking bench for bus_write_logger: directed scenarios plus random traffic
// compared against a queue-based model of the logger.
module tb_bus_write_logger;

  localparam int          DEPTH     = 16;
  localparam logic [31:0] SELF_BASE = 32'h0010_0000;
  localparam logic [31:0] SELF_MASK = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        arst_n = 1'b1;
  logic        snoop_req_i = 0, snoop_ack_i = 0, snoop_we_i = 0;
  logic [31:0] snoop_addr_i = 0, snoop_wdata_i = 0;
  logic [3:0]  snoop_be_i = 0;
  logic        host_req_i = 0, host_we_i = 0;
  logic [7:0]  host_addr_i = 0;
  logic [31:0] host_wdata_i = 0;
  logic        host_ack_o, host_resp_o;
  logic [31:0] host_rdata_o;

  int n_pass = 0;
  int n_total = 0;

  bus_write_logger dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .snoop_req_i  (snoop_req_i),
    .snoop_ack_i  (snoop_ack_i),
    .snoop_we_i   (snoop_we_i),
    .snoop_addr_i (snoop_addr_i),
    .snoop_be_i   (snoop_be_i),
    .snoop_wdata_i(snoop_wdata_i),
    .host_req_i   (host_req_i),
    .host_we_i    (host_we_i),
    .host_addr_i  (host_addr_i),
    .host_wdata_i (host_wdata_i),
    .host_ack_o   (host_ack_o),
    .host_resp_o  (host_resp_o),
    .host_rdata_o (host_rdata_o)
  );

  always #5 clk = ~clk;

  // Cycles since reset; the logger's timestamp is this minus the cycle of the last clear.
  int unsigned cyc;
  always @(posedge clk or negedge arst_n)
    if (!arst_n) cyc <= 0;
    else         cyc <= cyc + 1;

  typedef struct {
    logic [15:0] ts;
    logic [1:0]  ch;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_drop;
  bit          m_ovf, m_en, m_wrap;
  logic [1:0]  m_chen;
  logic [31:0] m_base[2];
  logic [31:0] m_mask[2];
  int unsigned ts_base;

  task automatic model_reset();
    q.delete();
    m_drop = 0; m_ovf = 0; m_en = 0; m_wrap = 0; m_chen = 0;
    m_base[0] = 0; m_base[1] = 0; m_mask[0] = 0; m_mask[1] = 0;
    ts_base = 0;
  endtask

  function automatic logic [31:0] exp_reg(input logic [7:0] a);
    logic [31:0] r;
    int n;
    r = 0;
    n = q.size();
    case (a)
      8'h00: r = {20'b0, 2'b0, m_chen, 6'b0, m_wrap, m_en};
      8'h04: begin
        r = 32'(n);
        r[16] = (n == DEPTH);
        r[17] = (n == 0);
        r[18] = m_ovf;
      end
      8'h08: r = m_drop;
      8'h10: r = m_base[0];
      8'h14: r = m_mask[0];
      8'h18: r = m_base[1];
      8'h1C: r = m_mask[1];
      8'h40: if (n > 0) r = 32'(q[0].ts);
      8'h44: if (n > 0) r = q[0].addr;
      8'h48: if (n > 0) r = q[0].data;
      8'h50: if (n > 0) r = {26'b0, q[0].ch, q[0].be};
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic set_idle();
    snoop_req_i = 0; snoop_ack_i = 0; snoop_we_i = 0;
    snoop_addr_i = 0; snoop_be_i = 0; snoop_wdata_i = 0;
    host_req_i = 0; host_we_i = 0; host_addr_i = 0; host_wdata_i = 0;
  endtask

  // One bus cycle, entered and left at a falling edge. The model advances on the pre-edge state.
  task automatic step(input bit sr, input bit sa, input bit sw, input logic [31:0] saddr,
                      input logic [3:0] sbe, input logic [31:0] sdata,
                      input bit hr, input bit hw, input logic [7:0] haddr, input logic [31:0] hwdata);
    ent_t e;
    int   ch;
    bit   cap, clr, pop;
    snoop_req_i = sr; snoop_ack_i = sa; snoop_we_i = sw;
    snoop_addr_i = saddr; snoop_be_i = sbe; snoop_wdata_i = sdata;
    host_req_i = hr; host_we_i = hw; host_addr_i = haddr; host_wdata_i = hwdata;

    ch = -1;
    for (int k = 0; k < 2; k++)
      if (ch < 0 && m_chen[k] && ((saddr & m_mask[k]) == (m_base[k] & m_mask[k]))) ch = k;
    cap = sr && sa && sw && m_en && (ch >= 0) &&
          ((saddr & SELF_MASK) != (SELF_BASE & SELF_MASK));
    clr = hr && hw && (haddr == 8'h00) && hwdata[2];
    pop = hr && hw && (haddr == 8'h4C);
    e.ts = 16'(cyc - ts_base);
    e.ch = 2'(ch);
    e.be = sbe;
    e.addr = saddr;
    e.data = sdata;

    if (clr) begin
      q.delete();
      m_drop = 0;
      m_ovf = 0;
      ts_base = cyc + 1;
    end else begin
      if (pop && q.size() > 0) void'(q.pop_front());
      if (cap) begin
        if (q.size() < DEPTH) q.push_back(e);
        else begin
          m_ovf = 1;
          if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
          if (m_wrap) begin
            void'(q.pop_front());
            q.push_back(e);
          end
        end
      end
    end
    if (hr && hw) begin
      case (haddr)
        8'h00: begin m_en = hwdata[0]; m_wrap = hwdata[1]; m_chen = hwdata[9:8]; end
        8'h10: m_base[0] = hwdata;
        8'h14: m_mask[0] = hwdata;
        8'h18: m_base[1] = hwdata;
        8'h1C: m_mask[1] = hwdata;
        default: ;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    set_idle();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic snoop_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    step(1, 1, 1, a, be, d, 0, 0, 0, 0);
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [31:0] d);
    step(0, 0, 0, 0, 0, 0, 1, 1, a, d);
  endtask

  task automatic host_rd(input logic [7:0] a, output logic [31:0] d);
    step(0, 0, 0, 0, 0, 0, 1, 0, a, 0);
    d = host_rdata_o;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    arst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    arst_n = 1;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    do_reset();
    n_total++;
    if (host_resp_o !== 1'b0 || host_rdata_o !== 32'h0)
      $display("FAIL reset_outputs resp=%b rdata=%h exp resp=0 rdata=0", host_resp_o, host_rdata_o);
    else n_pass++;
    host_rd(8'h04, got);
    n_total++;
    if (got !== 32'h0002_0000) $display("FAIL reset_status got=%h exp=%h", got, 32'h0002_0000);
    else n_pass++;
    host_rd(8'h00, got);
    n_total++;
    if (got !== 32'h0) $display("FAIL reset_ctrl got=%h exp=0", got);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [31:0] got;
    logic [7:0]  regs[6];
    logic [31:0] cst[6];
    host_wr(8'h10, 32'h8000_0000);
    host_wr(8'h14, 32'hFFFF_FFF0);
    host_wr(8'h00, 32'h101);
    snoop_wr(32'h8000_0000, 32'hDEAD_BEEF, 4'hF);
    snoop_wr(32'h9000_0000, 32'h1, 4'hF);
    regs = '{8'h04, 8'h44, 8'h48, 8'h50, 8'h40, 8'h00};
    cst  = '{32'h1, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0F, 32'h0, 32'h101};
    for (int i = 0; i < 6; i++) begin
      logic [31:0] exp;
      exp = exp_reg(regs[i]);
      if (i < 4 || i == 5) exp = cst[i];
      host_rd(regs[i], got);
      n_total++;
      if (got !== exp) $display("FAIL basic_reg%h got=%h exp=%h", regs[i], got, exp);
      else n_pass++;
    end
    host_wr(8'h4C, $urandom);
    host_rd(8'h04, got);
    n_total++;
    if (got !== 32'h0002_0000) $display("FAIL basic_pop_status got=%h exp=%h", got, 32'h0002_0000);
    else n_pass++;
  endtask

  task automatic test_fill(input bit wrap);
    logic [31:0] got;
    host_wr(8'h10, 32'h8000_0000);
    host_wr(8'h14, 32'hFFFF_FFF0);
    host_wr(8'h00, 32'h105 | (32'(wrap) << 1));
    for (int i = 0; i < 20; i++)
      snoop_wr(32'h8000_0000 | 32'($urandom_range(0, 15)), 32'(i), 4'($urandom));
    host_rd(8'h04, got);
    n_total++;
    if (got !== 32'h0005_0010) $display("FAIL fill_status wrap=%0d got=%h exp=%h", wrap, got, 32'h0005_0010);
    else n_pass++;
    host_rd(8'h08, got);
    n_total++;
    if (got !== 32'd4) $display("FAIL fill_dropped wrap=%0d got=%h exp=4", wrap, got);
    else n_pass++;
    host_rd(8'h48, got);
    n_total++;
    if (got !== (wrap ? 32'd4 : 32'd0)) $display("FAIL fill_head_data wrap=%0d got=%h exp=%h", wrap, got, wrap ? 32'd4 : 32'd0);
    else n_pass++;
    if (wrap) begin
      for (int i = 0; i < DEPTH; i++) begin
        logic [31:0] e_ts, e_data, g_ts;
        e_ts = exp_reg(8'h40);
        e_data = exp_reg(8'h48);
        host_rd(8'h40, g_ts);
        host_rd(8'h48, got);
        n_total++;
        if (g_ts !== e_ts || got !== e_data)
          $display("FAIL drain_entry%0d ts=%h data=%h exp ts=%h data=%h", i, g_ts, got, e_ts, e_data);
        else n_pass++;
        host_wr(8'h4C, 0);
      end
      host_rd(8'h04, got);
      n_total++;
      if (got !== 32'h0006_0000) $display("FAIL drain_status got=%h exp=%h", got, 32'h0006_0000);
      else n_pass++;
    end
  endtask

  task automatic test_overlap();
    logic [31:0] got;
    logic [3:0]  be;
    host_wr(8'h10, 32'h8000_0000);
    host_wr(8'h14, 32'hFFFF_FFF0);
    host_wr(8'h18, 32'h8000_0000);
    host_wr(8'h1C, 32'hFFFF_FF00);
    host_wr(8'h00, 32'h305);
    be = 4'($urandom);
    snoop_wr(32'h8000_0004, $urandom, be);
    host_rd(8'h50, got);
    n_total++;
    if (got !== {26'b0, 2'd0, be}) $display("FAIL overlap_ch0 got=%h exp=%h", got, {26'b0, 2'd0, be});
    else n_pass++;
    host_wr(8'h4C, 0);
    be = 4'($urandom);
    snoop_wr(32'h8000_0084, $urandom, be);
    host_rd(8'h50, got);
    n_total++;
    if (got !== {26'b0, 2'd1, be}) $display("FAIL overlap_ch1 got=%h exp=%h", got, {26'b0, 2'd1, be});
    else n_pass++;
    host_wr(8'h4C, 0);
    host_wr(8'h14, 32'h0);
    snoop_wr(32'h0010_002C, 32'h5555_5555, 4'hF);
    host_rd(8'h04, got);
    n_total++;
    if (got !== 32'h0002_0000) $display("FAIL self_excluded got=%h exp=%h", got, 32'h0002_0000);
    else n_pass++;
    snoop_wr(32'h0020_002C, 32'h6666_6666, 4'hF);
    host_rd(8'h44, got);
    n_total++;
    if (got !== 32'h0020_002C) $display("FAIL non_self_logged got=%h exp=%h", got, 32'h0020_002C);
    else n_pass++;
  endtask

  task automatic test_cap_pop_full();
    logic [31:0] got, exp;
    host_wr(8'h14, 32'hFFFF_FFF0);
    host_wr(8'h00, 32'h105);
    for (int i = 0; i < DEPTH; i++) snoop_wr(32'h8000_0000, 32'h100 + 32'(i), 4'hF);
    host_rd(8'h04, got);
    n_total++;
    if (got !== 32'h0001_0010) $display("FAIL full_no_ovf got=%h exp=%h", got, 32'h0001_0010);
    else n_pass++;
    step(1, 1, 1, 32'h8000_0008, 4'h3, 32'hCAFE_0001, 1, 1, 8'h4C, 0);
    host_rd(8'h04, got);
    n_total++;
    if (got !== 32'h0001_0010) $display("FAIL cap_pop_status got=%h exp=%h", got, 32'h0001_0010);
    else n_pass++;
    exp = exp_reg(8'h48);
    host_rd(8'h48, got);
    n_total++;
    if (got !== exp || got !== 32'h101) $display("FAIL cap_pop_head got=%h exp=%h", got, exp);
    else n_pass++;
    snoop_wr(32'h8000_0000, 32'hBAD, 4'hF);
    step(1, 1, 1, 32'h8000_0008, 4'h3, 32'hCAFE_0002, 1, 1, 8'h4C, 0);
    host_rd(8'h04, got);
    n_total++;
    if (got !== 32'h0005_0010) $display("FAIL cap_pop_ovf_kept got=%h exp=%h", got, 32'h0005_0010);
    else n_pass++;
    host_rd(8'h08, got);
    n_total++;
    if (got !== 32'd1) $display("FAIL cap_pop_dropped got=%h exp=1", got);
    else n_pass++;
    step(1, 1, 1, 32'h8000_0000, 4'hF, 32'h777, 1, 1, 8'h00, 32'h105);
    host_rd(8'h04, got);
    n_total++;
    if (got !== 32'h0002_0000) $display("FAIL clr_cap_status got=%h exp=%h", got, 32'h0002_0000);
    else n_pass++;
    host_rd(8'h08, got);
    n_total++;
    if (got !== 32'h0) $display("FAIL clr_cap_dropped got=%h exp=0", got);
    else n_pass++;
    host_rd(8'h00, got);
    n_total++;
    if (got !== 32'h101) $display("FAIL clr_ctrl_kept got=%h exp=%h", got, 32'h101);
    else n_pass++;
  endtask

  task automatic test_resp_timing();
    logic [31:0] exp;
    idle();
    exp = exp_reg(8'h04);
    host_req_i = 1; host_we_i = 0; host_addr_i = 8'h04;
    #1;
    n_total++;
    if (host_ack_o !== 1'b1 || host_resp_o !== 1'b0)
      $display("FAIL resp_before ack=%b resp=%b exp ack=1 resp=0", host_ack_o, host_resp_o);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    set_idle();
    n_total++;
    if (host_resp_o !== 1'b1 || host_rdata_o !== exp)
      $display("FAIL resp_pulse resp=%b rdata=%h exp resp=1 rdata=%h", host_resp_o, host_rdata_o, exp);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (host_resp_o !== 1'b0 || host_rdata_o !== exp || host_ack_o !== 1'b0)
      $display("FAIL resp_after resp=%b rdata=%h ack=%b exp resp=0 rdata=%h ack=0", host_resp_o, host_rdata_o, host_ack_o, exp);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] got, exp, a;
    logic [7:0]  regs[12];
    regs = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h40, 8'h44, 8'h48, 8'h50, 8'h3C};
    host_wr(8'h10, 32'h8000_0000);
    host_wr(8'h14, 32'hFFFF_FF00);
    host_wr(8'h18, 32'h0000_0000);
    host_wr(8'h1C, 32'hFF00_0000);
    host_wr(8'h00, 32'h305);
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 9);
      case ($urandom_range(0, 4))
        0: a = 32'h8000_0000 | 32'($urandom_range(0, 255));
        1: a = 32'h0000_0000 | 32'($urandom_range(0, 32'h00FF_FFFF));
        2: a = 32'h0010_0000 | 32'($urandom_range(0, 255));
        3: a = 32'h8000_0100 | 32'($urandom_range(0, 255));
        default: a = $urandom;
      endcase
      if (r <= 5)
        step($urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
             a, 4'($urandom), $urandom, $urandom_range(0, 4) == 0, 1, 8'h4C, $urandom);
      else if (r == 6) host_wr(8'h4C, $urandom);
      else if (r == 7) begin
        logic [7:0] ra;
        ra = regs[$urandom_range(0, 11)];
        exp = exp_reg(ra);
        host_rd(ra, got);
        n_total++;
        if (got !== exp) $display("FAIL random_reg%h iter=%0d got=%h exp=%h", ra, i, got, exp);
        else n_pass++;
      end else if (r == 8)
        host_wr(8'h00, 32'h300 | 32'($urandom_range(0, 1)) << 1 |
                32'($urandom_range(0, 7) != 0) | (($urandom_range(0, 9) == 0) ? 32'h4 : 32'h0));
      else idle();
    end
    for (int i = 0; i < 12; i++) begin
      exp = exp_reg(regs[i]);
      host_rd(regs[i], got);
      n_total++;
      if (got !== exp) $display("FAIL random_final_reg%h got=%h exp=%h", regs[i], got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    host_wr(8'h10, 32'h8000_0000);
    host_wr(8'h14, 32'hFFFF_FFF0);
    host_wr(8'h00, 32'h101);
    for (int i = 0; i < 5; i++) snoop_wr(32'h8000_0000, $urandom, 4'hF);
    host_rd(8'h04, got);
    arst_n = 0;
    #1;
    n_total++;
    if (host_resp_o !== 1'b0 || host_rdata_o !== 32'h0)
      $display("FAIL midreset_outputs resp=%b rdata=%h exp resp=0 rdata=0", host_resp_o, host_rdata_o);
    else n_pass++;
    model_reset();
    @(negedge clk);
    arst_n = 1;
    host_rd(8'h04, got);
    n_total++;
    if (got !== 32'h0002_0000) $display("FAIL midreset_status got=%h exp=%h", got, 32'h0002_0000);
    else n_pass++;
    host_rd(8'h00, got);
    n_total++;
    if (got !== 32'h0) $display("FAIL midreset_ctrl got=%h exp=0", got);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_fill(1'b0);
    test_fill(1'b1);
    test_overlap();
    test_cap_pop_full();
    test_resp_timing();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_write_logger.md
Name: bus_write_logger

Overview:
- Parametrised successor to the single-window CPU write logger on the sigma data bus.
- Passively snoops bus write transactions and filters them through N_CH programmable address windows.
- Captures {timestamp, channel, byte-enable, address, data} into a DEPTH-entry circular buffer.
- The host (CPU or UDM) configures the block and drains the buffer through a register slave port; supports stop-on-full and wrap (overwrite-oldest) modes, a drop counter and a sticky overflow flag.

Parameters:
- DEPTH, 16, buffer entries; power of 2, 2..256.
- N_CH, 2, number of address-filter channels, 1..4.
- TS_W, 16, timestamp counter width, 8..32.
- SELF_BASE, 32'h00100000, base address of this block; snooped writes to it are never logged.
- SELF_MASK, 32'hFFFFFF00, mask applied to the SELF_BASE comparison.

Ports:
- clk_i, in, 1: clock.
- arst_n_i, in, 1: asynchronous active-low reset.
- snoop_req_i, in, 1: bus request.
- snoop_ack_i, in, 1: bus acknowledge.
- snoop_we_i, in, 1: write enable.
- snoop_addr_i, in, 32: bus address.
- snoop_be_i, in, 4: byte enables.
- snoop_wdata_i, in, 32: write data.
- host_req_i, in, 1: register access request.
- host_we_i, in, 1: register write.
- host_addr_i, in, 8: byte offset; bits [7:2] are decoded.
- host_wdata_i, in, 32: register write data.
- host_ack_o, out, 1: accept, combinationally equal to host_req_i.
- host_resp_o, out, 1: read data valid.
- host_rdata_o, out, 32: read data.

Behaviour:
- Reset: all registers, pointers, count, DROPPED, OVF and timestamp are 0; host_resp_o=0; host_rdata_o=0; channels disabled; EN=0.
- Register map (unmapped reads return 0):
  - 0x00 CTRL: [0] EN, [1] WRAP, [2] CLR (write-1, self-clearing, reads 0), [11:8] channel enables.
  - 0x04 STATUS (RO): [15:0] COUNT, [16] FULL, [17] EMPTY, [18] OVF.
  - 0x08 DROPPED (RO): 32-bit, saturates at 0xFFFFFFFF.
  - 0x10+8k BASE_k and 0x14+8k MASK_k, for k<N_CH.
  - 0x40 HEAD_TS, zero-extended.
  - 0x44 HEAD_ADDR.
  - 0x48 HEAD_DATA.
  - 0x4C POP: a write of any value pops the head entry.
  - 0x50 HEAD_INFO: [3:0] be, [5:4] channel.
- Host reads: host_resp_o pulses 1 cycle after the accepted read, with host_rdata_o valid in the same cycle; host_rdata_o holds its value afterwards. Host writes take effect at the accepting edge. HEAD_* registers read 0 when EMPTY.
- Timestamp: free-running TS_W counter, increments every cycle, wraps modulo 2^TS_W, zeroed by CLR. A captured entry holds the counter value of the handshake cycle.
- Capture condition, all evaluated in the same cycle:
  - snoop_req_i & snoop_ack_i & snoop_we_i & EN.
  - Some enabled channel k satisfies (addr & MASK_k)==(BASE_k & MASK_k).
  - (addr & SELF_MASK) != (SELF_BASE & SELF_MASK).
  - If several channels match, the lowest k is recorded.
- Buffer updates:
  - Capture with buffer not full: write at tail, tail++, COUNT++.
  - Full and WRAP=0: entry dropped, DROPPED++, OVF=1.
  - Full and WRAP=1: oldest entry overwritten; head++ and tail++, COUNT stays DEPTH, OVF=1, DROPPED++.
  - Pointers wrap modulo DEPTH.
- POP: when non-empty, head++ and COUNT--. When empty, ignored with no error.
- Capture and POP in the same cycle: both apply and COUNT is unchanged. If the buffer was full, the pop frees the slot, so there is no overwrite, no drop and no OVF.
- CLR has priority over a same-cycle capture or POP. It zeroes pointers, COUNT, OVF, DROPPED and timestamp. CTRL enables and filter registers are preserved.
- Changing WRAP or the filter registers affects only subsequent cycles. Buffer contents are untouched.
- Reset asserted mid-operation clears everything asynchronously. host_resp_o is deasserted immediately.
- Buffer storage is flop-based and latency-free: HEAD_* registers reflect a pop in the cycle after it.

Test Plan:
- Reset, then read STATUS -> 0x00020000 (EMPTY); read CTRL -> 0.
- Ch0 BASE=0x80000000, MASK=0xFFFFFFF0, CTRL=0x101; snoop writes 0x80000000<-0xDEADBEEF (be=F) and 0x90000000<-1 -> COUNT=1, HEAD_ADDR=0x80000000, HEAD_DATA=0xDEADBEEF, HEAD_INFO=0x0F; POP -> EMPTY=1.
- DEPTH=16, WRAP=0: 20 matching writes with data 0..19 -> COUNT=16, FULL=1, OVF=1, DROPPED=4, HEAD_DATA=0. Same sequence with WRAP=1 -> HEAD_DATA=4, DROPPED=4.
- Ch0 and ch1 windows overlap at 0x80000004 -> HEAD_INFO[5:4]=0. Snoop write to 0x0010002C with ch0 MASK=0 -> not logged.
- Full buffer, capture and POP in the same cycle -> COUNT stays 16, OVF unchanged, DROPPED unchanged. CLR together with a capture -> COUNT=0, DROPPED=0.
- Host read of 0x04 -> host_resp_o high exactly 1 cycle later. Assert arst_n_i mid-fill -> STATUS=0x00020000 after release.
